// File: rtl/imu_spi_seq_pkg.sv
// imu_spi_pkg: shared state encoding, read commands and default config words for imu_spi_seq
package imu_spi_pkg;
  typedef enum logic [2:0] {PWRUP, CFG_A, CFG_B, CFG_C, WAIT_INT, RD_LO, RD_HI} imu_state_t;
  localparam logic [15:0] CMD_YAW_LO = 16'hA600;
  localparam logic [15:0] CMD_YAW_HI = 16'hA700;
  localparam logic [15:0] CFG0_DEF = 16'h0D02;
  localparam logic [15:0] CFG1_DEF = 16'h1160;
  localparam logic [15:0] CFG2_DEF = 16'h1440;
endpackage

// File: rtl/imu_spi_seq.sv
// imu_spi_seq: power-up wait, three config writes, then yaw-rate read pairs on each data-ready interrupt
// Ports: clk/rst_n (async active-low); INT sensor data-ready (async level);
//   done/rd_data from the SPI monarch; wrt/wt_data start pulse and command to it;
//   cfg_done sticky config-complete flag; yaw_rt/vld signed yaw rate with one-cycle strobe.
module imu_spi_seq
  import imu_spi_pkg::*;
#(
  parameter int PWRUP_CYCLES = 65536,
  parameter logic [15:0] CFG0 = CFG0_DEF,
  parameter logic [15:0] CFG1 = CFG1_DEF,
  parameter logic [15:0] CFG2 = CFG2_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] wt_data,
  output logic        cfg_done,
  output logic [15:0] yaw_rt,
  output logic        vld
);
  localparam int TW = $clog2(PWRUP_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(PWRUP_CYCLES - 1);
  imu_state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic int_ff, int_s, done_ff, done_rise;
  logic wrt_n, vld_n, cfg_done_n;
  logic [15:0] wt_data_n, yaw_n;
  logic [7:0] lo_byte, lo_n;
  logic unused_hi;
  assign unused_hi = ^rd_data[15:8];
  // done stays high from the previous transfer until the monarch restarts, so only its edge advances the FSM
  assign done_rise = done & ~done_ff;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PWRUP;
      timer    <= '0;
      int_ff   <= 1'b0;
      int_s    <= 1'b0;
      done_ff  <= 1'b0;
      wrt      <= 1'b0;
      wt_data  <= 16'h0000;
      cfg_done <= 1'b0;
      yaw_rt   <= 16'h0000;
      vld      <= 1'b0;
      lo_byte  <= 8'h00;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      int_ff   <= INT;
      int_s    <= int_ff;
      done_ff  <= done;
      wrt      <= wrt_n;
      wt_data  <= wt_data_n;
      cfg_done <= cfg_done_n;
      yaw_rt   <= yaw_n;
      vld      <= vld_n;
      lo_byte  <= lo_n;
    end
  end
  always_comb begin
    state_n    = state;
    timer_n    = timer;
    wrt_n      = 1'b0;
    wt_data_n  = wt_data;
    cfg_done_n = cfg_done;
    yaw_n      = yaw_rt;
    vld_n      = 1'b0;
    lo_n       = lo_byte;
    case (state)
      PWRUP: begin
        timer_n = timer + TW'(1);
        if (timer == LAST) begin
          wrt_n = 1'b1;
          wt_data_n = CFG0;
          state_n = CFG_A;
        end
      end
      CFG_A: if (done_rise) begin
        wrt_n = 1'b1;
        wt_data_n = CFG1;
        state_n = CFG_B;
      end
      CFG_B: if (done_rise) begin
        wrt_n = 1'b1;
        wt_data_n = CFG2;
        state_n = CFG_C;
      end
      CFG_C: if (done_rise) begin
        cfg_done_n = 1'b1;
        state_n = WAIT_INT;
      end
      WAIT_INT: if (int_s) begin
        wrt_n = 1'b1;
        wt_data_n = CMD_YAW_LO;
        state_n = RD_LO;
      end
      RD_LO: if (done_rise) begin
        lo_n = rd_data[7:0];
        wrt_n = 1'b1;
        wt_data_n = CMD_YAW_HI;
        state_n = RD_HI;
      end
      RD_HI: if (done_rise) begin
        yaw_n = {rd_data[7:0], lo_byte};
        vld_n = 1'b1;
        state_n = WAIT_INT;
      end
      default: state_n = PWRUP;
    endcase
  end
endmodule
